// File: rtl/tx_uart_if.sv
// Host-side bundle for tx_uart: baud tick, request/data in, serial line and status out.
interface tx_uart_if #(
  parameter int unsigned NB_DATA = 8
) ();
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_tx_done;

  modport master (
    output i_tick, i_tx_start, i_data,
    input  o_tx, o_busy, o_tx_done
  );

  modport slave (
    input  i_tick, i_tx_start, i_data,
    output o_tx, o_busy, o_tx_done
  );
endinterface

// File: rtl/tx_uart.sv
// UART transmitter: start bit, NB_DATA bits LSB first, SB_TICK-tick stop period,
// paced by a 16x oversampling baud tick.
module tx_uart #(
  parameter int unsigned NB_DATA  = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned NB_STATE = 2
) (
  input  logic     i_clock,
  input  logic     i_reset_n,
  tx_uart_if.slave bus
);

  localparam int unsigned NB_S = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  typedef enum logic [NB_STATE-1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [NB_S-1:0]    s_q, s_d;
  logic [NB_N-1:0]    n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic               tx_q, tx_d;
  logic               done;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_tx_start) begin
          b_d     = bus.i_data;
          s_d     = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bus.i_tick) begin
          if (s_q == NB_S'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + NB_S'(1);
          end
        end
      end
      StData: begin
        if (bus.i_tick) begin
          if (s_q == NB_S'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NB_N'(NB_DATA - 1)) begin
              state_d = StStop;
            end else begin
              n_d = n_q + NB_N'(1);
            end
          end else begin
            s_d = s_q + NB_S'(1);
          end
        end
      end
      StStop: begin
        if (bus.i_tick) begin
          if (s_q == NB_S'(SB_TICK - 1)) begin
            done    = 1'b1;
            s_d     = '0;
            state_d = StIdle;
          end else begin
            s_d = s_q + NB_S'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is looked up from the next state so o_tx is registered yet
    // already shows the new bit in the first cycle after the transition.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_busy    = (state_q != StIdle);
  assign bus.o_tx_done = done;

endmodule

// File: doc/tx_uart.md
# tx_uart

UART transmitter: serialises one parallel data word per request onto a single line as start bit, NB_DATA data bits (LSB first), and a stop period. Paces each bit from an external baud tick at 16× oversampling, the same tick source that feeds the receiver. Sits between the host-side logic (e.g. an ALU result or a FIFO read port) and the `o_tx` pad.

## Interface

Parameters:
- `NB_DATA`, 8: data bits per frame.
- `SB_TICK`, 16: baud ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `NB_STATE`, 2: state register width.

Ports:
- `i_clock`, in, 1: system clock; all state changes on its rising edge.
- `i_reset_n`, in, 1: reset, asynchronous, active-low.
- `i_tick`, in, 1: baud tick, one-cycle pulse at 16× baud rate.
- `i_tx_start`, in, 1: transmit request, sampled only in IDLE.
- `i_data`, in, NB_DATA: word to send, captured on the accept cycle.
- `o_tx`, out, 1: serial line, idle high, registered.
- `o_busy`, out, 1: high whenever state ≠ IDLE.
- `o_tx_done`, out, 1: one-cycle pulse when the stop period ends.

## Operation

Registers:
- state (NB_STATE bits)
- tick counter `s` (4 bits)
- bit counter `n` (clog2(NB_DATA) bits)
- shift register `b` (NB_DATA bits)
- `tx_reg` driving `o_tx`

Reset (asynchronous, takes effect immediately):
- state = IDLE, `s` = 0, `n` = 0, `b` = 0.
- `o_tx` = 1, `o_busy` = 0, `o_tx_done` = 0.

States:
- **IDLE**
  - `tx_reg` = 1.
  - If `i_tx_start` = 1: capture `b` ← `i_data`, set `s` ← 0, go to START.
  - `i_tick` is ignored.
- **START**
  - `tx_reg` = 0.
  - On `i_tick`: if `s` = 15, set `s` ← 0, `n` ← 0, go to DATA; otherwise `s` ← `s` + 1.
- **DATA**
  - `tx_reg` = `b[0]`.
  - On `i_tick` with `s` = 15: set `s` ← 0 and `b` ← `b` >> 1.
    - If `n` = NB_DATA−1, go to STOP.
    - Otherwise `n` ← `n` + 1.
  - On `i_tick` with `s` < 15: `s` ← `s` + 1.
- **STOP**
  - `tx_reg` = 1.
  - On `i_tick`: if `s` = SB_TICK−1, assert `o_tx_done` for that one cycle and go to IDLE; otherwise `s` ← `s` + 1.
  - `s` is widened to clog2(SB_TICK) bits when SB_TICK > 16.

Rules:
- Cycles without `i_tick` hold every register except state transitions out of IDLE.
- `i_tx_start` outside IDLE is ignored; no queuing.
- `i_data` changes after the accept cycle do not affect the frame in flight.
- The return to IDLE and a new `i_tx_start` can be back to back: IDLE accepts the request one cycle after `o_tx_done`. There is no extra idle bit beyond the stop period.
- The `o_tx_done` cycle and a simultaneous `i_tx_start` are independent; the request is ignored because state is still STOP on that edge.
- Reset mid-frame aborts the frame: `o_tx` returns high asynchronously and no `o_tx_done` is produced.

## Timing

- `o_tx` is registered: it reflects the state entered at edge k from cycle k+1.
  - Accept at edge k puts `o_tx` low from k+1.
  - `o_busy` is high from k+1.
- Frame length in ticks: 16 (start) + 16·NB_DATA (data) + SB_TICK (stop). This is 160 with the defaults.
- With `i_tick` tied high the frame is 160 clock cycles:
  - `o_tx` low for cycles k+1..k+16.
  - Bit i occupies cycles k+17+16i .. k+32+16i.
  - Stop is high from k+145.
  - `o_tx_done` is high exactly in cycle k+160, the cycle whose edge returns state to IDLE.
  - `o_busy` falls at k+161.
- Each bit boundary is the edge where `i_tick` = 1 and the counter reaches its terminal value.
- `o_tx_done` coincides with the final tick of STOP.
- `o_tx_done` and `o_busy` are never both low during a frame. `o_busy` is still high during the `o_tx_done` cycle.

## Test plan

- **Reset:** hold `i_reset_n` = 0, toggle all inputs → `o_tx` = 1, `o_busy` = 0, `o_tx_done` = 0 throughout; release → line stays high with no request.
- **Single frame:** `i_tick` tied high, `i_data` = 0xA5, one-cycle `i_tx_start` → `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles; `o_tx_done` pulse exactly 160 cycles after accept; `o_busy` high for 160 cycles.
- **Sparse tick:** `i_tick` every 5th cycle, `i_data` = 0x00 → each bit held 80 cycles; `o_tx` high only during stop; decode through a reference receiver model yields 0x00.
- **Ignored inputs:** mid-frame `i_tx_start` pulses plus `i_data` changed to 0xFF on the cycle after accepting 0x3C → transmitted word is 0x3C, exactly one `o_tx_done`.
- **Back-to-back:** `i_tx_start` held high continuously with data 0x11 then 0x22 → second start bit begins 161 cycles after the first accept; no gap beyond the stop period; two `o_tx_done` pulses.
- **Reset mid-frame:** assert `i_reset_n` = 0 during data bit 3 of 0x0F, asynchronously between edges → `o_tx` goes high without waiting for a clock edge, no `o_tx_done`; next request after release sends a full clean frame.
